// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated-window frequency meter: FSM state
// encoding, window-length derivation and counter-width helper.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // Number of system clock cycles in one measurement window.
   function automatic int gate_cycles(input int clk_hz, input int gate_hz);
      return clk_hz / gate_hz;
   endfunction

   // ceil(log2(value)), never less than 1 so a counter always has a bit.
   function automatic int clog2_w(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            w = i + 1;
         end
      end
      if (w == 0) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Brings the asynchronous measured signal into the clk domain through a
// 2-FF synchroniser, keeps one history flop and flags rising edges.
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic o_edge
);

   logic r_meta;
   logic r_sync;
   logic r_hist;

   // Synchroniser chain followed by the history flop used for edge compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_hist <= 1'b0;
      end else begin
         r_meta <= async_in;
         r_sync <= r_meta;
         r_hist <= r_sync;
      end
   end

   // Single-cycle pulse when the synchronised level has just gone high.
   assign o_edge = r_sync & ~r_hist;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts rising edges of sig_in over a window
// of CLK_HZ/GATE_HZ clock cycles and returns the count via valid/ready.
// Optional macro FREQ_METER_CONT_EN: after each accepted result the next
// window starts immediately instead of returning to IDLE.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int GATE_HZ = 1,
   parameter int CNT_W   = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             ovf,
   output logic             valid,
   input  logic             ready,
   output logic             busy
);

   localparam int GATE_CYCLES = gate_cycles(CLK_HZ, GATE_HZ);
   localparam int GATE_W      = clog2_w(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   state_t             r_state;
   logic [GATE_W-1:0]  r_gate;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_sticky;
   logic               w_edge;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_ovf_next;

   edge_sync u_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (sig_in),
      .o_edge   (w_edge)
   );

   // Saturating next count and sticky overflow, including this cycle's edge.
   always_comb begin
      w_cnt_next = r_cnt;
      w_ovf_next = r_sticky;
      if (w_edge) begin
         if (r_cnt == CNT_MAX) begin
            w_ovf_next = 1'b1;
         end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
         end
      end else begin
         w_cnt_next = r_cnt;
      end
   end

   // Window FSM with gate counter, edge counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_gate   <= '0;
         r_cnt    <= '0;
         r_sticky <= 1'b0;
         freq     <= '0;
         ovf      <= 1'b0;
         valid    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  r_gate   <= '0;
                  r_cnt    <= '0;
                  r_sticky <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= ST_MEASURE;
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_MEASURE: begin
               r_cnt    <= w_cnt_next;
               r_sticky <= w_ovf_next;
               if (r_gate == GATE_LAST) begin
                  freq    <= w_cnt_next;
                  ovf     <= w_ovf_next;
                  valid   <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= ST_DONE;
               end else begin
                  r_gate <= r_gate + GATE_W'(1);
               end
            end
            ST_DONE: begin
               if (valid && ready) begin
                  valid <= 1'b0;
`ifdef FREQ_METER_CONT_EN
                  r_gate   <= '0;
                  r_cnt    <= '0;
                  r_sticky <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= ST_MEASURE;
`else
                  r_state  <= ST_IDLE;
`endif
               end else begin
                  valid <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               valid   <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (100-cycle window). Define
// FREQ_METER_CONT_EN for both RTL and bench to exercise continuous mode.
module tb_freq_meter;

`ifdef FREQ_METER_CONT_EN
   localparam int CNT_W = 6;
`else
   localparam int CNT_W = 4;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             sig_in = 1'b0;
   logic             ready = 1'b0;
   logic [CNT_W-1:0] freq;
   logic             ovf;
   logic             valid;
   logic             busy;

   int n_tests = 0;
   int n_fail  = 0;
   int period  = 0;

   typedef struct {
      logic [CNT_W-1:0] f;
      logic             o;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      int               period;
      logic [CNT_W-1:0] f;
      logic             o;
   } vec_t;
   vec_t vecs[5];

   freq_meter #(.CLK_HZ(1000), .GATE_HZ(10), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sig_in (sig_in),
      .freq   (freq),
      .ovf    (ovf),
      .valid  (valid),
      .ready  (ready),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Square-wave generator: one rising edge every 'period' clocks (0 = low).
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(negedge clk);
         #2;
         if (period == 0) begin
            sig_in = 1'b0;
            ph = 0;
         end else begin
            if (ph >= period - 1) ph = 0;
            else ph++;
            sig_in = (ph < period / 2);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Pulse start, wait for valid (bounded), check latency and scoreboard.
   task automatic run_window(input logic inject, output int n);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         start = inject && (n == 20 || n == 60);
         if (n == 1) chk("busy_t1", 32'(busy), 32'd1);
         if (valid || n >= 400) break;
      end
      start = 1'b0;
      chk("valid_latency", 32'(n), 32'd101);
      chk("busy_in_done", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("freq", 32'(freq), 32'(e.f));
         chk("ovf", 32'(ovf), 32'(e.o));
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("valid_drop", 32'(valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   // Watch for n cycles and report any unexpected valid/busy.
   task automatic quiet(input int n, input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (valid || busy) seen = 1;
      end
      chk(name, 32'(seen), 32'd0);
   endtask

   initial begin
      int n;
      logic [CNT_W-1:0] f0;
      vecs[0] = '{10, CNT_W'(10), 1'b0};
      vecs[1] = '{4,  CNT_W'(15), 1'b1};
      vecs[2] = '{20, CNT_W'(5),  1'b0};
      vecs[3] = '{0,  CNT_W'(0),  1'b0};
      vecs[4] = '{50, CNT_W'(2),  1'b0};

      // Reset state
      period = 10;
      repeat (3) @(negedge clk);
      chk("rst_freq", 32'(freq), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      quiet(30, "no_auto_start");

`ifndef FREQ_METER_CONT_EN
      // Table-driven windows
      for (int i = 0; i < 5; i++) begin
         period = vecs[i].period;
         repeat (20) @(negedge clk);
         exp_q.push_back('{vecs[i].f, vecs[i].o});
         run_window(1'b0, n);
         handshake();
      end

      // Backpressure: ready low for 50 cycles keeps result stable
      period = 10;
      repeat (10) @(negedge clk);
      exp_q.push_back('{CNT_W'(10), 1'b0});
      run_window(1'b0, n);
      f0 = freq;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (valid !== 1'b1 || freq !== f0) chk("hold_stable", 32'(freq), 32'(f0));
      end
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_freq", 32'(freq), 32'd10);
      handshake();

      // Start pulses inside the window are ignored
      period = 20;
      repeat (10) @(negedge clk);
      exp_q.push_back('{CNT_W'(5), 1'b0});
      run_window(1'b1, n);
      handshake();
      quiet(150, "single_result");

      // Reset mid-window
      period = 10;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_freq", 32'(freq), 32'd0);
      chk("mid_rst_ovf", 32'(ovf), 32'd0);
      chk("mid_rst_valid", 32'(valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet(150, "no_result_after_rst");
`else
      // Continuous mode: back-to-back windows every 101 cycles
      period = 5;
      ready = 1'b1;
      repeat (10) @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end while (!valid && n < 400);
      chk("cont_first_latency", 32'(n), 32'd101);
      for (int k = 0; k < 3; k++) begin
         chk("cont_count", 32'(freq >= CNT_W'(19) && freq <= CNT_W'(21)), 32'd1);
         chk("cont_ovf", 32'(ovf), 32'd0);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!valid && n < 400);
         chk("cont_period", 32'(n), 32'd101);
      end
      chk("cont_last_count", 32'(freq >= CNT_W'(19) && freq <= CNT_W'(21)), 32'd1);
      ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("cont_rst_valid", 32'(valid), 32'd0);
      chk("cont_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet(150, "cont_needs_start");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
